// File: rtl/keypad_scanner.sv
// 4-row x 3-column key matrix scanner. Drives one column low at a time,
// assembles a 12-bit frame and commits it once it is stable for DEBOUNCE_SCANS frames.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [2:0]  col_out,
    output logic [11:0] keystroke,
    output logic        key_changed
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int MC_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [MC_W-1:0]  MC_MAX   = MC_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_e;

    logic [DIV_W-1:0] r_div_cnt;
    col_e             r_col_idx;
    logic [2:0]       r_col_out;
    logic [11:0]      r_frame;
    logic [11:0]      r_candidate;
    logic [MC_W-1:0]  r_match_cnt;
    logic [11:0]      r_keystroke;
    logic             r_key_changed;

    logic             w_sample;
    logic             w_frame_end;
    col_e             w_col_next;
    logic [2:0]       w_col_drive;
    logic [11:0]      w_frame_next;
    logic [MC_W-1:0]  w_match_next;
    logic             w_commit;

    assign w_sample    = (r_div_cnt == DIV_LAST);
    assign w_frame_end = w_sample && (r_col_idx == COL2);

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it holding state (no latch).
    always_comb begin
        w_frame_next = r_frame;
        w_col_next   = COL0;
        w_col_drive  = 3'b110;
        case (r_col_idx)
            COL0: begin
                w_frame_next[3:0] = ~row_in;
                w_col_next        = COL1;
                w_col_drive       = 3'b101;
            end
            COL1: begin
                w_frame_next[7:4] = ~row_in;
                w_col_next        = COL2;
                w_col_drive       = 3'b011;
            end
            default: begin
                w_frame_next[11:8] = ~row_in;
            end
        endcase
    end

    // Match count saturates so an indefinitely held pattern never re-commits.
    always_comb begin
        w_match_next = MC_W'(1);
        if (w_frame_next == r_candidate) begin
            w_match_next = (r_match_cnt >= MC_MAX) ? MC_MAX : r_match_cnt + MC_W'(1);
        end
    end

    assign w_commit = (w_match_next >= MC_MAX) && (w_frame_next != r_keystroke);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_col_idx     <= COL0;
            r_col_out     <= 3'b110;
            r_frame       <= '0;
            r_candidate   <= '0;
            r_match_cnt   <= '0;
            r_keystroke   <= '0;
            r_key_changed <= 1'b0;
        end else begin
            r_key_changed <= 1'b0;
            if (w_sample) begin
                r_div_cnt <= '0;
                r_frame   <= w_frame_next;
                r_col_idx <= w_col_next;
                r_col_out <= w_col_drive;
                if (w_frame_end) begin
                    r_candidate <= w_frame_next;
                    r_match_cnt <= w_match_next;
                    if (w_commit) begin
                        r_keystroke   <= w_frame_next;
                        r_key_changed <= 1'b1;
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    assign col_out     = r_col_out;
    assign keystroke   = r_keystroke;
    assign key_changed = r_key_changed;

endmodule
